// File: rtl/scrolling_text_buffer.sv
// scrolling_text_buffer: editable symbol line with cursor, scroll window, valid/ready opcode port (clk, reset, cmd*) and per-item iterator (iter_*, cursor_*, length, cursor, scroll)
module scrolling_text_buffer #(
  parameter int SYMBOL_WIDTH = 7,
  parameter int SYMBOLS_COUNT = 127,
  parameter int VISIBLE_COUNT = 32,
  localparam int LENGTH_WIDTH = $clog2(SYMBOLS_COUNT + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              cmd,
  input  logic [SYMBOL_WIDTH-1:0] cmd_symbol,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  output logic                    cmd_err,
  input  logic                    full_iter_en,
  input  logic                    visible_iter_en,
  output logic [SYMBOL_WIDTH-1:0] iter_out,
  output logic                    iter_out_valid,
  output logic                    iter_last,
  output logic                    cursor_left,
  output logic                    cursor_right,
  output logic [LENGTH_WIDTH-1:0] length,
  output logic [LENGTH_WIDTH-1:0] cursor,
  output logic [LENGTH_WIDTH-1:0] scroll
);
  localparam int LW = LENGTH_WIDTH;
  localparam int IW = $clog2(SYMBOLS_COUNT);
  localparam logic [LW-1:0] CAP = LW'(SYMBOLS_COUNT);
  localparam logic [LW-1:0] VM1 = LW'(VISIBLE_COUNT - 1);
  localparam logic [2:0] C_INS = 3'd0, C_LEFT = 3'd1, C_RIGHT = 3'd2, C_END = 3'd4,
                         C_BSP = 3'd5, C_DEL = 3'd6, C_CLR = 3'd7;
  typedef enum logic [1:0] {IDLE, SHIFT, ITER} state_t;
  state_t state, state_n;
  logic [SYMBOL_WIDTH-1:0] mem [SYMBOLS_COUNT];
  logic [SYMBOL_WIDTH-1:0] sym, rd;
  logic [2:0] op, op_e;
  logic [LW-1:0] ptr, k, cm1, cnt, cur_n, len_n, scr_n;
  logic [LW:0] idx;
  logic acc, bad, go, shop, zero, done, fin, start, step, fm, last, full_mode;
  always_comb begin
    acc = cmd_valid && state == IDLE;
    cm1 = cursor - 1'b1;
    bad = cmd == C_INS ? length == CAP || cmd_symbol == '0 :
          cmd == C_LEFT || cmd == C_BSP ? cursor == '0 :
          cmd == C_RIGHT || cmd == C_DEL ? cursor == length : 1'b0;
    go = acc && !bad;
    shop = cmd == C_INS || cmd == C_BSP || cmd == C_DEL;
    k = cmd == C_BSP ? cm1 : cursor;
    zero = cmd == C_INS ? length == cursor : k == length - 1'b1;
    done = op == C_INS ? ptr == cursor + 1'b1 : ptr == length - 2'd2;
    fin = go && shop && zero || state == SHIFT && done;
    op_e = state == SHIFT ? op : cmd;
    start = state == IDLE && !cmd_valid && (full_iter_en || visible_iter_en);
    step = start || state == ITER && (full_iter_en || visible_iter_en);
    fm = state == IDLE ? full_iter_en : full_mode;
    idx = fm ? {1'b0, cnt} : {1'b0, scroll} + {1'b0, cnt};
    last = fm ? cnt == length : cnt == VM1;
    rd = idx < {1'b0, length} ? mem[IW'(idx)] : '0;
  end
  always_comb begin
    cur_n = cursor;
    len_n = length;
    if (go && !shop) begin
      cur_n = cmd == C_LEFT ? cm1 : cmd == C_RIGHT ? cursor + 1'b1 : cmd == C_END ? length : '0;
      len_n = cmd == C_CLR ? '0 : length;
    end
    if (fin) begin
      cur_n = op_e == C_INS ? cursor + 1'b1 : op_e == C_BSP ? cm1 : cursor;
      len_n = op_e == C_INS ? length + 1'b1 : length - 1'b1;
    end
    scr_n = cur_n < scroll ? cur_n : cur_n - scroll > VM1 ? cur_n - VM1 : scroll;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb state_n = state == IDLE ? (go && shop && !zero ? SHIFT : start && !last ? ITER : IDLE) :
                        state == SHIFT ? (done ? IDLE : SHIFT) : (step && last ? IDLE : ITER);
  always_comb cmd_ready = state == IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      length <= '0;
      cursor <= '0;
      scroll <= '0;
      cnt <= '0;
      cmd_err <= 1'b0;
      iter_out_valid <= 1'b0;
      iter_out <= '0;
      iter_last <= 1'b0;
      cursor_left <= 1'b0;
      cursor_right <= 1'b0;
    end else begin
      length <= len_n;
      cursor <= cur_n;
      scroll <= scr_n;
      cmd_err <= acc && bad;
      iter_out_valid <= step;
      iter_out <= step ? rd : '0;
      iter_last <= step && last;
      cursor_left <= step && idx == {1'b0, cursor};
      cursor_right <= step && cursor != '0 && idx == {1'b0, cm1};
      cnt <= step ? (last ? '0 : cnt + 1'b1) : cnt;
      if (start) full_mode <= full_iter_en;
    end
    if (go && shop) begin
      op <= cmd;
      sym <= cmd_symbol;
      ptr <= cmd == C_INS ? length : k;
    end else if (state == SHIFT) ptr <= op == C_INS ? ptr - 1'b1 : ptr + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (state == SHIFT) mem[IW'(ptr)] <= op == C_INS ? mem[IW'(ptr - 1'b1)] : mem[IW'(ptr + 1'b1)];
    if (fin && op_e == C_INS) mem[IW'(cursor)] <= state == SHIFT ? sym : cmd_symbol;
  end
endmodule
